// File: rtl/div_sequencer_if.sv
// div_sequencer_if: issue/result bundle between the EX stage and the
// iterative RV32M divide/remainder sequencer.
//   start    : EX-stage divide/remainder instruction valid this cycle
//   op       : 00 div, 01 divu, 10 rem, 11 remu
//   a, b     : dividend (rs1) and divisor (rs2)
//   kill     : abort the operation in flight (pipeline flush)
//   stall_EX : hold fetch and EX, suppress regwrite
//   busy     : sequencer is not idle
//   done     : one-cycle pulse, result valid
//   result   : quotient or remainder, held until the next completion
// The pipeline side uses the master modport, the sequencer the slave modport.
interface div_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        stall_EX;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, op, a, b, kill,
    input  stall_EX, busy, done, result
  );

  modport slave (
    input  start, op, a, b, kill,
    output stall_EX, busy, done, result
  );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: 32-cycle restoring divider for RV32M div/divu/rem/remu.
// Operands are captured once on issue; the sequencer then runs one
// restoring step per cycle on magnitudes, applies the sign fix-up on the
// last step and presents a registered result with a one-cycle done pulse.
// Divide-by-zero and signed overflow either finish immediately
// (EARLY_SPECIAL=1) or run the full iteration and have their architectural
// value substituted at the end (EARLY_SPECIAL=0).
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset, overrides start and kill
//   bus : div_sequencer_if slave modport (see the interface file)
module div_sequencer #(
  parameter bit EARLY_SPECIAL = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        rem_sel_q;   // 1: return remainder, 0: return quotient
  logic        sign_a_q;    // dividend negative (signed ops only)
  logic        sign_b_q;    // divisor negative (signed ops only)
  logic        special_q;   // divide-by-zero or signed overflow captured
  logic [31:0] spec_q;      // architectural value for the special case
  logic [31:0] dvd_q;       // dividend, shifted out as quotient shifts in
  logic [31:0] dvs_q;       // divisor magnitude
  logic [31:0] rem_q;       // partial remainder
  logic [31:0] result_q;
  logic        done_q;

  // Capture-side decode of the incoming instruction.
  logic        is_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        div_zero;
  logic        sign_ovf;
  logic        special;
  logic [31:0] spec_val;
  logic        accept;

  // NOTE: every signal driven in always_comb gets a default at the top so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    is_signed = ~bus.op[0];
    mag_a     = bus.a;
    mag_b     = bus.b;
    if (is_signed && bus.a[31]) mag_a = -bus.a;
    if (is_signed && bus.b[31]) mag_b = -bus.b;

    div_zero = (bus.b == 32'd0);
    sign_ovf = is_signed && (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
    special  = div_zero || sign_ovf;

    // Divide by zero: q = all ones, r = dividend. Overflow: q = INT_MIN, r = 0.
    if (bus.op[1]) spec_val = div_zero ? bus.a : 32'd0;
    else           spec_val = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;

    accept = (state_q == IDLE) && bus.start && !bus.kill;
  end

  // One restoring step. The shifted remainder is 33 bits so a divisor of
  // 0xFFFFFFFF still compares and subtracts correctly.
  logic [32:0] rem_shift;
  logic [32:0] rem_sub;
  logic        q_bit;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] final_val;

  always_comb begin
    rem_shift = {rem_q, dvd_q[31]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    q_bit     = (rem_shift >= {1'b0, dvs_q});
    rem_nxt   = q_bit ? rem_sub[31:0] : rem_shift[31:0];
    quo_nxt   = {dvd_q[30:0], q_bit};

    // Truncating division: quotient sign is the xor of the operand signs,
    // remainder takes the sign of the dividend.
    quo_fix = (sign_a_q ^ sign_b_q) ? -quo_nxt : quo_nxt;
    rem_fix = sign_a_q ? -rem_nxt : rem_nxt;

    final_val = rem_sel_q ? rem_fix : quo_fix;
    if (special_q) final_val = spec_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      rem_sel_q <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      special_q <= 1'b0;
      spec_q    <= 32'd0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      rem_q     <= 32'd0;
      result_q  <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            rem_sel_q <= bus.op[1];
            sign_a_q  <= is_signed & bus.a[31];
            sign_b_q  <= is_signed & bus.b[31];
            special_q <= special;
            spec_q    <= spec_val;
            dvd_q     <= mag_a;
            dvs_q     <= mag_b;
            rem_q     <= 32'd0;
            cnt_q     <= 5'd0;
            if (EARLY_SPECIAL && special) begin
              state_q  <= DONE;
              result_q <= spec_val;
              done_q   <= 1'b1;
            end else begin
              state_q <= ITER;
            end
          end
        end
        ITER: begin
          if (bus.kill) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_nxt;
            dvd_q <= quo_nxt;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q  <= DONE;
              result_q <= final_val;
              done_q   <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The issuing cycle stalls combinationally; DONE releases the stall so the
  // held instruction retires with the result. A flush drops the stall at once.
  assign bus.stall_EX = !rst && !bus.kill &&
                        (((state_q == IDLE) && bus.start) || (state_q == ITER));
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer. Two instances share clk/rst: inst 0 is
// built with EARLY_SPECIAL=0, inst 1 with EARLY_SPECIAL=1. Each operation
// is logged per cycle (cycle 0 = issue cycle) and then checked against
// hand-computed values.
module tb_div_sequencer;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int         NCYC    = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_sequencer_if bus0 ();
  div_sequencer_if bus1 ();

  logic        st [2];
  logic        kl [2];
  logic [1:0]  opv [2];
  logic [31:0] av [2];
  logic [31:0] bv [2];

  assign bus0.start = st[0];
  assign bus0.kill  = kl[0];
  assign bus0.op    = opv[0];
  assign bus0.a     = av[0];
  assign bus0.b     = bv[0];
  assign bus1.start = st[1];
  assign bus1.kill  = kl[1];
  assign bus1.op    = opv[1];
  assign bus1.a     = av[1];
  assign bus1.b     = bv[1];

  div_sequencer #(.EARLY_SPECIAL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  div_sequencer #(.EARLY_SPECIAL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int tests = 0;
  int fails = 0;

  logic done_log  [0:NCYC];
  logic stall_log [0:NCYC];
  logic busy_log  [0:NCYC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] res_of(input int s);
    return (s == 1) ? bus1.result : bus0.result;
  endfunction

  function automatic logic done_of(input int s);
    return (s == 1) ? bus1.done : bus0.done;
  endfunction

  function automatic logic stall_of(input int s);
    return (s == 1) ? bus1.stall_EX : bus0.stall_EX;
  endfunction

  function automatic logic busy_of(input int s);
    return (s == 1) ? bus1.busy : bus0.busy;
  endfunction

  function automatic int first_done();
    for (int i = 0; i <= NCYC; i++)
      if (done_log[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_done();
    int n = 0;
    for (int i = 0; i <= NCYC; i++) n += int'(done_log[i] === 1'b1);
    return n;
  endfunction

  function automatic int count_stall();
    int n = 0;
    for (int i = 0; i <= NCYC; i++) n += int'(stall_log[i] === 1'b1);
    return n;
  endfunction

  // Issue one operation on instance s and log NCYC+1 cycles. Operands are
  // scrambled after issue; optional kill / rst at a given cycle; poke
  // re-asserts start (other operands) in ITER (cycle 5) and DONE (cycle 33).
  task automatic run_op(input int s, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int kill_at, input int rst_at,
                        input bit poke);
    @(negedge clk);
    st[s] = 1'b1; opv[s] = op; av[s] = a; bv[s] = b; kl[s] = 1'b0;
    #1;
    done_log[0] = done_of(s); stall_log[0] = stall_of(s); busy_log[0] = busy_of(s);
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clk);
      if (poke && (c == 5 || c == 33)) begin
        st[s] = 1'b1; opv[s] = OP_DIVU; av[s] = 32'd50; bv[s] = 32'd5;
      end else begin
        st[s] = 1'b0; opv[s] = ~op; av[s] = ~a; bv[s] = ~b;
      end
      kl[s] = (c == kill_at);
      rst   = (c == rst_at);
      #1;
      done_log[c] = done_of(s); stall_log[c] = stall_of(s); busy_log[c] = busy_of(s);
    end
    @(negedge clk);
    st[s] = 1'b0; kl[s] = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b1; kl[i] = 1'b0; opv[i] = OP_DIVU; av[i] = 32'd9; bv[i] = 32'd3;
    end
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall0", 32'(stall_of(0)), 32'd0);
    check("rst_stall1", 32'(stall_of(1)), 32'd0);
    check("rst_result", res_of(1), 32'd0);
    check("rst_done",   32'(done_of(1)), 32'd0);
    check("rst_busy",   32'(busy_of(1)), 32'd0);
    @(negedge clk);
    rst = 1'b0; st[0] = 1'b0; st[1] = 1'b0;

    // divu 100/7: full latency and stall window
    run_op(1, OP_DIVU, 32'd100, 32'd7, -1, -1, 1'b0);
    check("divu_done_cyc",   32'(first_done()), 32'd33);
    check("divu_done_cnt",   32'(count_done()), 32'd1);
    check("divu_stall_cnt",  32'(count_stall()), 32'd33);
    check("divu_stall_c0",   32'(stall_log[0]), 32'd1);
    check("divu_stall_c32",  32'(stall_log[32]), 32'd1);
    check("divu_stall_c33",  32'(stall_log[33]), 32'd0);
    check("divu_busy_c1",    32'(busy_log[1]), 32'd1);
    check("divu_busy_c33",   32'(busy_log[33]), 32'd1);
    check("divu_busy_c34",   32'(busy_log[34]), 32'd0);
    check("divu_result",     res_of(1), 32'd14);

    // signed fix-up
    run_op(1, OP_REM, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0);
    check("rem_m7_2", res_of(1), 32'hFFFF_FFFF);
    run_op(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0);
    check("div_m7_2", res_of(1), 32'hFFFF_FFFD);
    run_op(0, OP_DIV, 32'd7, 32'hFFFF_FFFE, -1, -1, 1'b0);
    check("div_7_m2", res_of(0), 32'hFFFF_FFFD);
    run_op(0, OP_REM, 32'd7, 32'hFFFF_FFFE, -1, -1, 1'b0);
    check("rem_7_m2", res_of(0), 32'd1);

    // divide by zero
    run_op(1, OP_DIV, 32'd5, 32'd0, -1, -1, 1'b0);
    check("dz_early_cyc", 32'(first_done()), 32'd1);
    check("dz_early_res", res_of(1), 32'hFFFF_FFFF);
    run_op(0, OP_REMU, 32'd5, 32'd0, -1, -1, 1'b0);
    check("dz_full_cyc", 32'(first_done()), 32'd33);
    check("dz_full_res", res_of(0), 32'd5);
    run_op(0, OP_REM, 32'hFFFF_FFFB, 32'd0, -1, -1, 1'b0);
    check("dz_rem_neg", res_of(0), 32'hFFFF_FFFB);

    // signed overflow
    run_op(1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
    check("ovf_div_cyc", 32'(first_done()), 32'd1);
    check("ovf_div_res", res_of(1), 32'h8000_0000);
    run_op(1, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
    check("ovf_rem_res", res_of(1), 32'd0);
    run_op(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
    check("ovf_full_cyc", 32'(first_done()), 32'd33);
    check("ovf_full_res", res_of(0), 32'h8000_0000);

    // wide divisor
    run_op(1, OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0);
    check("divu_max_max", res_of(1), 32'd1);
    run_op(1, OP_DIVU, 32'hFFFF_FFFF, 32'd1, -1, -1, 1'b0);
    check("divu_max_1", res_of(1), 32'hFFFF_FFFF);

    // start ignored in ITER and DONE
    run_op(1, OP_DIVU, 32'd1000, 32'd10, -1, -1, 1'b1);
    check("poke_done_cnt", 32'(count_done()), 32'd1);
    check("poke_done_cyc", 32'(first_done()), 32'd33);
    check("poke_busy_c34", 32'(busy_log[34]), 32'd0);
    check("poke_result",   res_of(1), 32'd100);

    run_op(1, OP_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, -1, -1, 1'b0);
    check("remu_wide", res_of(1), 32'hFFFF_FFFE);

    // kill in ITER
    run_op(1, OP_DIVU, 32'h0000_FFFF, 32'd3, 10, -1, 1'b0);
    check("kill_stall_c10", 32'(stall_log[10]), 32'd0);
    check("kill_busy_c11",  32'(busy_log[11]), 32'd0);
    check("kill_no_done",   32'(count_done()), 32'd0);
    check("kill_result",    res_of(1), 32'hFFFF_FFFE);

    // kill with start in IDLE
    @(negedge clk);
    st[1] = 1'b1; kl[1] = 1'b1; opv[1] = OP_DIVU; av[1] = 32'd8; bv[1] = 32'd2;
    #1;
    check("kill_idle_stall", 32'(stall_of(1)), 32'd0);
    @(negedge clk);
    st[1] = 1'b0; kl[1] = 1'b0;
    #1;
    check("kill_idle_busy", 32'(busy_of(1)), 32'd0);

    // kill in DONE is ignored
    run_op(1, OP_DIVU, 32'd9, 32'd3, 33, -1, 1'b0);
    check("kill_done_cyc", 32'(first_done()), 32'd33);
    check("kill_done_res", res_of(1), 32'd3);

    // reset mid-operation
    run_op(1, OP_DIVU, 32'd77, 32'd7, -1, 20, 1'b0);
    check("rst_mid_stall", 32'(stall_log[20]), 32'd0);
    check("rst_mid_busy",  32'(busy_log[21]), 32'd0);
    check("rst_mid_done",  32'(count_done()), 32'd0);
    check("rst_mid_res",   res_of(1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
